led_fade_pwm: RTL and testbench

Per-channel LED brightness engine that drives the board LED/user_io pins in place of raw counter bits. It accepts brightness targets over a valid/ready write port and ramps each channel's current level toward its target, one step per fade tick. Each channel is rendered as an 8-bit PWM waveform. The block sits directly downstream of the top-level pattern/counter logic, which becomes its write master.

---
 rtl/led_pkg.sv | 20 ++
 rtl/led_pwm_channel.sv | 29 ++
 rtl/led_fade_pwm.sv | 149 ++++++++++++++
 tb/tb_led_fade_pwm.sv | 392 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// led_pkg : shared constants and types for the LED fade/PWM engine
// Rev 1.0
// ----------------------------------------------------------------------------
package led_pkg;

   localparam int LED_CHANNELS = 6;
   localparam int LED_PWM_BITS = 8;
   localparam int LED_STEP_DIV = 60000;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_t;

   typedef logic [LED_PWM_BITS-1:0] level_t;

endpackage
`default_nettype wire

// File: rtl/led_pwm_channel.sv
`default_nettype none
// ----------------------------------------------------------------------------
// led_pwm_channel : one registered PWM output compared against a shared counter
// Rev 1.0
// ----------------------------------------------------------------------------
module led_pwm_channel
   import led_pkg::*;
#(
   parameter int PWM_BITS = LED_PWM_BITS
) (
   input  logic                clk_60mhz,
   input  logic                rst,
   input  logic [PWM_BITS-1:0] level,
   input  logic [PWM_BITS-1:0] pwm_cnt,
   input  logic                enable,
   output logic                led
);

   // Strict compare: level 0 never lights, full scale gives 255/256 duty.
   always_ff @(posedge clk_60mhz or posedge rst) begin
      if (rst) begin
         led <= 1'b0;
      end else begin
         led <= enable && (level > pwm_cnt);
      end
   end

endmodule
`default_nettype wire

// File: rtl/led_fade_pwm.sv
`default_nettype none
// ----------------------------------------------------------------------------
// led_fade_pwm : per-channel brightness targets ramped one step per fade tick
// Rev 1.0
// ----------------------------------------------------------------------------
module led_fade_pwm
   import led_pkg::*;
#(
   parameter int CHANNELS = LED_CHANNELS,
   parameter int PWM_BITS = LED_PWM_BITS,
   parameter int STEP_DIV = LED_STEP_DIV
) (
   input  logic                clk_60mhz,
   input  logic                rst,
   input  logic                wr_valid,
   output logic                wr_ready,
   input  logic [2:0]          wr_chan,
   input  logic [PWM_BITS-1:0] wr_level,
   input  logic                enable,
   output logic [CHANNELS-1:0] led,
   output logic                tick,
   output logic                busy,
   output logic                wr_err
);

   localparam int                  PS_W     = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
   localparam logic [PS_W-1:0]     PS_LAST  = PS_W'(STEP_DIV - 1);
   localparam logic [PS_W-1:0]     PS_ONE   = PS_W'(1);
   localparam logic [PWM_BITS-1:0] LVL_ONE  = PWM_BITS'(1);
   localparam logic [3:0]          CHAN_LIM = 4'(CHANNELS);
   localparam logic [2:0]          IDX_LAST = 3'(CHANNELS - 1);

   logic [PS_W-1:0]     prescaler;
   logic [PWM_BITS-1:0] pwm_cnt;
   logic [PWM_BITS-1:0] target  [CHANNELS];
   logic [PWM_BITS-1:0] current [CHANNELS];
   state_t              state;
   logic [2:0]          idx;
   logic                wr_fire;
   logic                chan_ok;

   assign wr_fire = wr_valid && wr_ready;
   assign chan_ok = ({1'b0, wr_chan} < CHAN_LIM);
   assign tick    = (prescaler == PS_LAST);

   always_ff @(posedge clk_60mhz or posedge rst) begin
      if (rst) begin
         prescaler <= '0;
      end else if (prescaler == PS_LAST) begin
         prescaler <= '0;
      end else begin
         prescaler <= prescaler + PS_ONE;
      end
   end

   always_ff @(posedge clk_60mhz or posedge rst) begin
      if (rst) begin
         pwm_cnt <= '0;
      end else begin
         pwm_cnt <= pwm_cnt + LVL_ONE;
      end
   end

   // wr_ready is only high in IDLE, so targets never change under a scan.
   always_ff @(posedge clk_60mhz or posedge rst) begin
      if (rst) begin
         wr_err <= 1'b0;
         for (int i = 0; i < CHANNELS; i++) begin
            target[i] <= '0;
         end
      end else if (wr_fire) begin
         if (!chan_ok) begin
            wr_err <= 1'b1;
         end
         for (int i = 0; i < CHANNELS; i++) begin
            if (wr_chan == 3'(i)) begin
               target[i] <= wr_level;
            end
         end
      end
   end

   always_ff @(posedge clk_60mhz or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         idx      <= '0;
         wr_ready <= 1'b0;
         for (int i = 0; i < CHANNELS; i++) begin
            current[i] <= '0;
         end
      end else begin
         case (state)
            IDLE: begin
               wr_ready <= !tick;
               if (tick) begin
                  state <= SCAN;
                  idx   <= '0;
               end
            end
            SCAN: begin
               // Step toward target only when unequal, so no wrap or overshoot.
               for (int i = 0; i < CHANNELS; i++) begin
                  if (idx == 3'(i)) begin
                     if (current[i] < target[i]) begin
                        current[i] <= current[i] + LVL_ONE;
                     end else if (current[i] > target[i]) begin
                        current[i] <= current[i] - LVL_ONE;
                     end
                  end
               end
               if (idx == IDX_LAST) begin
                  state    <= IDLE;
                  idx      <= '0;
                  wr_ready <= 1'b1;
               end else begin
                  idx <= idx + 3'd1;
               end
            end
            default: begin
               state    <= IDLE;
               idx      <= '0;
               wr_ready <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      busy = 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
         busy = busy | (current[i] != target[i]);
      end
   end

   for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
      led_pwm_channel #(
         .PWM_BITS (PWM_BITS)
      ) u_chan (
         .clk_60mhz (clk_60mhz),
         .rst       (rst),
         .level     (current[g]),
         .pwm_cnt   (pwm_cnt),
         .enable    (enable),
         .led       (led[g])
      );
   end

endmodule
`default_nettype wire

// File: tb/tb_led_fade_pwm.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_led_fade_pwm : randomized checks of led_fade_pwm against a tick-level model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_led_fade_pwm;

   localparam int NCH = 6;
   localparam int SD  = 8;

   logic           clk_60mhz = 1'b0;
   logic           rst       = 1'b1;
   logic           wr_valid  = 1'b0;
   logic [2:0]     wr_chan   = '0;
   logic [7:0]     wr_level  = '0;
   logic           enable    = 1'b1;
   logic           wr_ready;
   logic [NCH-1:0] led;
   logic           tick;
   logic           busy;
   logic           wr_err;

   int n_checks = 0;
   int n_fail   = 0;

   int cyc;
   int m_tgt [8];
   int m_cur [8];
   bit m_err;
   int duty  [NCH];

   always #5 clk_60mhz = ~clk_60mhz;

   led_fade_pwm #(
      .CHANNELS (NCH),
      .PWM_BITS (8),
      .STEP_DIV (SD)
   ) dut (
      .clk_60mhz (clk_60mhz),
      .rst       (rst),
      .wr_valid  (wr_valid),
      .wr_ready  (wr_ready),
      .wr_chan   (wr_chan),
      .wr_level  (wr_level),
      .enable    (enable),
      .led       (led),
      .tick      (tick),
      .busy      (busy),
      .wr_err    (wr_err)
   );

   // Cycle c after release: no writes in cycle 0, none during the NCH-cycle scan after each tick.
   function automatic bit ready_at(int c);
      return (c >= 1) && ((c < SD) || ((c % SD) >= NCH));
   endfunction

   // Reference: targets take writes; every tick moves each level one step toward its target.
   always @(posedge clk_60mhz or posedge rst) begin
      if (rst) begin
         cyc   = 0;
         m_err = 1'b0;
         for (int i = 0; i < 8; i++) begin
            m_tgt[i] = 0;
            m_cur[i] = 0;
         end
      end else begin
         if (wr_valid && ready_at(cyc)) begin
            if (int'(wr_chan) < NCH) m_tgt[wr_chan] = int'(wr_level);
            else m_err = 1'b1;
         end
         if (cyc % SD == SD - 1) begin
            for (int i = 0; i < NCH; i++) begin
               if (m_cur[i] < m_tgt[i]) m_cur[i] = m_cur[i] + 1;
               else if (m_cur[i] > m_tgt[i]) m_cur[i] = m_cur[i] - 1;
            end
         end
         cyc = cyc + 1;
      end
   end

   task automatic do_write(input logic [2:0] ch, input logic [7:0] lvl, output bit ok);
      ok       = 1'b0;
      wr_valid = 1'b1;
      wr_chan  = ch;
      wr_level = lvl;
      for (int k = 0; k < 64; k++) begin
         if (wr_ready === 1'b1) begin
            ok = 1'b1;
            @(negedge clk_60mhz);
            break;
         end
         @(negedge clk_60mhz);
      end
      wr_valid = 1'b0;
   endtask

   task automatic wait_scan_done();
      int k = 0;
      do begin
         @(negedge clk_60mhz);
         k++;
      end while (!((cyc >= SD) && (cyc % SD == NCH)) && (k < 4 * SD));
   endtask

   task automatic wait_settled(input int max_cyc, output bit ok);
      ok = 1'b0;
      for (int k = 0; k < max_cyc; k++) begin
         @(negedge clk_60mhz);
         if ((busy === 1'b0) && (cyc >= SD) && (cyc % SD == NCH)) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic count_duty();
      for (int i = 0; i < NCH; i++) duty[i] = 0;
      repeat (256) begin
         @(negedge clk_60mhz);
         for (int i = 0; i < NCH; i++) duty[i] += int'(led[i]);
      end
   endtask

   task automatic test_reset();
      bit ok;
      repeat (3) @(negedge clk_60mhz);
      n_checks++;
      if (led !== '0 || wr_ready !== 1'b0 || busy !== 1'b0 || tick !== 1'b0 || wr_err !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_hold: led=%b ready=%b busy=%b tick=%b err=%b, want all 0",
                  led, wr_ready, busy, tick, wr_err);
      end
      rst = 1'b0;
      do_write(3'd5, 8'd50, ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL reset_pre_write: accepted=%0d want 1", ok); end
      repeat (40) @(negedge clk_60mhz);
      n_checks++;
      if (busy !== 1'b1) begin n_fail++; $display("FAIL reset_pre_busy: got %b want 1", busy); end
      rst = 1'b1;
      #1;
      n_checks++;
      if (led !== '0 || wr_ready !== 1'b0 || busy !== 1'b0 || dut.current[5] !== 8'd0 || dut.target[5] !== 8'd0) begin
         n_fail++;
         $display("FAIL reset_mid_ramp: led=%b ready=%b busy=%b cur5=%0d tgt5=%0d, want 0",
                  led, wr_ready, busy, dut.current[5], dut.target[5]);
      end
      repeat (2) @(negedge clk_60mhz);
      rst = 1'b0;
      n_checks++;
      if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready_cycle0: got %b want 0", wr_ready); end
      for (int c = 1; c <= SD; c++) begin
         logic exp_t;
         @(negedge clk_60mhz);
         exp_t = (c == SD - 1);
         n_checks++;
         if (tick !== exp_t) begin
            n_fail++;
            $display("FAIL reset_tick_cycle%0d: got %b want %b", c, tick, exp_t);
         end
         if (c == 1) begin
            n_checks++;
            if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready_first_edge: got %b want 1", wr_ready); end
         end
      end
   endtask

   task automatic test_ramp_up();
      bit ok;
      do_write(3'd2, 8'd3, ok);
      n_checks++;
      if (!ok || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL ramp_up_write: accepted=%0d busy=%b want 1/1", ok, busy);
      end
      for (int t = 1; t <= 3; t++) begin
         wait_scan_done();
         n_checks++;
         if (dut.current[2] !== 8'(t)) begin
            n_fail++;
            $display("FAIL ramp_up_tick%0d: got %0d want %0d", t, dut.current[2], t);
         end
      end
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL ramp_up_busy_done: got %b want 0", busy); end
      count_duty();
      n_checks++;
      if (duty[2] != 3 || duty[0] != 0 || duty[1] != 0 || duty[3] != 0 || duty[4] != 0 || duty[5] != 0) begin
         n_fail++;
         $display("FAIL ramp_up_duty: got %0d/%0d/%0d/%0d/%0d/%0d want 0/0/3/0/0/0",
                  duty[0], duty[1], duty[2], duty[3], duty[4], duty[5]);
      end
   endtask

   task automatic test_ramp_down();
      bit ok;
      do_write(3'd0, 8'd5, ok);
      wait_settled(200, ok);
      n_checks++;
      if (!ok || dut.current[0] !== 8'd5) begin
         n_fail++;
         $display("FAIL ramp_down_settle5: settled=%0d cur0=%0d want 1/5", ok, dut.current[0]);
      end
      do_write(3'd0, 8'd2, ok);
      for (int t = 1; t <= 5; t++) begin
         int exp_l;
         wait_scan_done();
         exp_l = (t <= 3) ? 5 - t : 2;
         n_checks++;
         if (int'(dut.current[0]) != exp_l) begin
            n_fail++;
            $display("FAIL ramp_down_tick%0d: got %0d want %0d", t, dut.current[0], exp_l);
         end
      end
      do_write(3'd1, 8'd255, ok);
      wait_settled(2400, ok);
      n_checks++;
      if (!ok || dut.current[1] !== 8'd255) begin
         n_fail++;
         $display("FAIL ramp_full_scale: settled=%0d cur1=%0d want 1/255", ok, dut.current[1]);
      end
      count_duty();
      n_checks++;
      if (duty[1] != 255 || duty[0] != 2 || duty[2] != 3) begin
         n_fail++;
         $display("FAIL full_scale_duty: got %0d/%0d/%0d want 2/255/3", duty[0], duty[1], duty[2]);
      end
   endtask

   task automatic test_handshake();
      int low;
      int k;
      int acc_phase;
      k = 0;
      do begin @(negedge clk_60mhz); k++; end while (!((cyc >= SD) && (cyc % SD == SD - 1)) && k < 4 * SD);
      @(negedge clk_60mhz);
      wr_valid = 1'b1;
      wr_chan  = 3'd4;
      wr_level = 8'd9;
      low = 0;
      while (wr_ready !== 1'b1 && low < 20) begin
         low++;
         @(negedge clk_60mhz);
      end
      acc_phase = cyc % SD;
      @(negedge clk_60mhz);
      wr_valid = 1'b0;
      n_checks++;
      if (low != NCH || acc_phase != NCH) begin
         n_fail++;
         $display("FAIL hold_ready_low: low=%0d phase=%0d want %0d/%0d", low, acc_phase, NCH, NCH);
      end
      n_checks++;
      if (dut.target[4] !== 8'd9) begin n_fail++; $display("FAIL hold_target: got %0d want 9", dut.target[4]); end
      k = 0;
      do begin @(negedge clk_60mhz); k++; end while (!(cyc % SD == SD - 1) && k < 4 * SD);
      wr_valid = 1'b1;
      wr_chan  = 3'd3;
      wr_level = 8'd7;
      n_checks++;
      if (tick !== 1'b1 || wr_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL same_cycle_pre: tick=%b ready=%b want 1/1", tick, wr_ready);
      end
      @(negedge clk_60mhz);
      wr_valid = 1'b0;
      n_checks++;
      if (dut.target[3] !== 8'd7 || wr_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL same_cycle_accept: tgt3=%0d ready=%b want 7/0", dut.target[3], wr_ready);
      end
      wait_scan_done();
      n_checks++;
      if (dut.current[3] !== 8'd1) begin n_fail++; $display("FAIL same_cycle_scan: got %0d want 1", dut.current[3]); end
   endtask

   task automatic test_invalid();
      bit ok;
      bit tgt_ok;
      do_write(3'd7, 8'd99, ok);
      n_checks++;
      if (!ok || wr_err !== m_err || wr_err !== 1'b1) begin
         n_fail++;
         $display("FAIL invalid_err: accepted=%0d err=%b want 1/1", ok, wr_err);
      end
      tgt_ok = 1'b1;
      for (int i = 0; i < NCH; i++) if (int'(dut.target[i]) != m_tgt[i]) tgt_ok = 1'b0;
      n_checks++;
      if (!tgt_ok) begin n_fail++; $display("FAIL invalid_targets: changed=%0d want 0", !tgt_ok); end
      repeat (50) @(negedge clk_60mhz);
      n_checks++;
      if (wr_err !== 1'b1) begin n_fail++; $display("FAIL invalid_sticky: got %b want 1", wr_err); end
   endtask

   task automatic test_random();
      bit ok;
      int bad;
      for (int r = 0; r < 6; r++) begin
         logic [2:0] ch;
         logic [7:0] lv;
         ch = 3'($urandom_range(0, NCH - 1));
         lv = 8'($urandom_range(0, 24));
         do_write(ch, lv, ok);
         repeat ($urandom_range(0, 20)) @(negedge clk_60mhz);
      end
      wait_settled(2400, ok);
      bad = 0;
      for (int i = 0; i < NCH; i++) if (int'(dut.current[i]) != m_cur[i] || m_cur[i] != m_tgt[i]) bad++;
      n_checks++;
      if (!ok || bad != 0) begin
         n_fail++;
         $display("FAIL random_levels: settled=%0d mismatched_channels=%0d want 1/0", ok, bad);
      end
      count_duty();
      bad = 0;
      for (int i = 0; i < NCH; i++) if (duty[i] != m_cur[i]) bad++;
      n_checks++;
      if (bad != 0) begin n_fail++; $display("FAIL random_duty: mismatched_channels=%0d want 0", bad); end
   endtask

   task automatic test_enable();
      bit ok;
      int lit;
      do_write(3'd3, 8'd128, ok);
      wait_settled(2400, ok);
      n_checks++;
      if (!ok || dut.current[3] !== 8'd128) begin
         n_fail++;
         $display("FAIL enable_level128: settled=%0d cur3=%0d want 1/128", ok, dut.current[3]);
      end
      do_write(3'd3, 8'd200, ok);
      enable = 1'b0;
      lit = 0;
      repeat (100) begin
         @(negedge clk_60mhz);
         if (led !== '0) lit++;
      end
      n_checks++;
      if (lit != 0) begin n_fail++; $display("FAIL enable_gate: lit_cycles=%0d want 0", lit); end
      wait_scan_done();
      n_checks++;
      if (int'(dut.current[3]) != m_cur[3] || dut.current[3] <= 8'd128) begin
         n_fail++;
         $display("FAIL enable_ramp_continues: got %0d want %0d", dut.current[3], m_cur[3]);
      end
      enable = 1'b1;
      wait_settled(2400, ok);
      count_duty();
      n_checks++;
      if (!ok || duty[3] != 200 || duty[1] != m_cur[1]) begin
         n_fail++;
         $display("FAIL enable_resume_duty: got %0d/%0d want 200/%0d", duty[3], duty[1], m_cur[1]);
      end
   endtask

   task automatic test_reset_clears();
      bit ok;
      do_write(3'd5, 8'd200, ok);
      repeat (40) @(negedge clk_60mhz);
      rst = 1'b1;
      #1;
      n_checks++;
      if (wr_err !== 1'b0 || busy !== 1'b0 || led !== '0 || dut.current[5] !== 8'd0) begin
         n_fail++;
         $display("FAIL reset_clears: err=%b busy=%b led=%b cur5=%0d want 0", wr_err, busy, led, dut.current[5]);
      end
      repeat (2) @(negedge clk_60mhz);
      rst = 1'b0;
      repeat (2) @(negedge clk_60mhz);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: time limit reached, got timeout want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_ramp_up();
      test_ramp_down();
      test_handshake();
      test_invalid();
      test_random();
      test_enable();
      test_reset_clears();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
